// File: rtl/sift_sched_pkg.sv
// sift_sched_pkg: FSM encoding, default frame geometry and result entry width for the SIFT frame scheduler.
package sift_sched_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  localparam int DEF_WIDE = 256;
  localparam int DEF_HIGN = 256;
  localparam int DEF_DW = 8;
  localparam int DEF_CNT_DW = 16;
  localparam int DEF_RES_W = 2 * DEF_CNT_DW;
  function automatic int res_w(input int cnt_dw);
    return 2 * cnt_dw;
  endfunction
endpackage

// File: rtl/sift_res_fifo.sv
// sift_res_fifo: shifting result FIFO whose head is slot 0, so dout comes straight from a register.
module sift_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] shifted [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] wa;
  logic do_pop;
  logic do_push;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wa = cnt - CW'(do_pop);
  assign dout = mem[0];
  always_comb begin
    shifted[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH - 1; i++) shifted[i] = mem[i+1];
  end
  // a pop shifts every slot down, so the push lands one slot lower
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (do_push && wa == CW'(i)) ? din : do_pop ? shifted[i] : mem[i];
    end
  end
endmodule

// File: rtl/sift_frame_sched.sv
// sift_frame_sched: streams an image pair to the matcher and buffers match results.
// Define SIFT_SCHED_PERF_EN to add the perf_cyc pause-cycle counter.
module sift_frame_sched
  import sift_sched_pkg::*;
#(
  parameter int WIDE = DEF_WIDE,
  parameter int HIGN = DEF_HIGN,
  parameter int DW = DEF_DW,
  parameter int CNT_DW = DEF_CNT_DW,
  parameter int DRAIN_CYC = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  output logic                  rd_en,
  output logic [CNT_DW-1:0]     rd_addr,
  input  logic [DW-1:0]         rd_data1,
  input  logic [DW-1:0]         rd_data2,
  output logic                  valid_in,
  output logic [DW-1:0]         data_in1,
  output logic [DW-1:0]         data_in2,
  input  logic                  valid_match,
  input  logic [2*CNT_DW-1:0]   match_addr,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*CNT_DW-1:0]   res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
`ifdef SIFT_SCHED_PERF_EN
  output logic [31:0]           perf_cyc,
`endif
  output logic [CNT_DW-1:0]     match_cnt
);
  localparam int RW = res_w(CNT_DW);
  localparam int DCW = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_DW-1:0] LAST = CNT_DW'(WIDE * HIGN - 1);
  state_t state;
  state_t state_nxt;
  logic [DCW-1:0] drain_cnt;
  logic go;
  logic pop;
  logic full;
  logic empty;
  assign go = state == IDLE && start;
  assign rd_en = state == STREAM && !pause;
  assign busy = state == STREAM || state == DRAIN;
  assign done = state == DONE;
  assign data_in1 = valid_in ? rd_data1 : '0;
  assign data_in2 = valid_in ? rd_data2 : '0;
  assign res_valid = !empty;
  assign pop = res_valid && res_ready;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? STREAM : IDLE;
      STREAM:  state_nxt = abort ? IDLE : (rd_en && rd_addr == LAST) ? DRAIN : STREAM;
      DRAIN:   state_nxt = abort ? IDLE : (drain_cnt == DCW'(DRAIN_CYC - 1)) ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // rd_addr parks on the last pixel rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_addr <= '0;
      drain_cnt <= '0;
      valid_in <= 1'b0;
      match_cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      valid_in <= rd_en;
      rd_addr <= go ? '0 : (rd_en && rd_addr != LAST) ? rd_addr + 1'b1 : rd_addr;
      drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      match_cnt <= go ? '0 : (valid_match && state != IDLE && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
      ovf <= go ? 1'b0 : (valid_match && full && !pop) ? 1'b1 : ovf;
    end
  end
`ifdef SIFT_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) perf_cyc <= '0;
    else perf_cyc <= go ? '0 : (busy && pause) ? perf_cyc + 32'd1 : perf_cyc;
  end
`endif
  sift_res_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(go),
    .push(valid_match),
    .din(match_addr),
    .pop(pop),
    .full(full),
    .empty(empty),
    .dout(res_data)
  );
endmodule

// File: tb/tb_sift_frame_sched.sv
// tb_sift_frame_sched: directed frames against a frame-level reference model on a 4x4 image.
module tb_sift_frame_sched;
  localparam int W = 4, H = 4, DW = 8, CDW = 16, DC = 8, FD = 4, N = W * H;
  logic clk = 0, rst = 1, start = 0, abort = 0, pause = 0, res_ready = 0, valid_match = 0;
  logic [31:0] match_addr = '0;
  logic [DW-1:0] rd_data1 = '0, rd_data2 = '0;
  logic rd_en, valid_in, res_valid, busy, done, ovf;
  logic [CDW-1:0] rd_addr, match_cnt;
  logic [DW-1:0] data_in1, data_in2;
  logic [31:0] res_data;
`ifdef SIFT_SCHED_PERF_EN
  logic [31:0] perf_cyc;
`endif
  int checks = 0, errors = 0, vin_seen = 0, done_seen = 0;

  sift_frame_sched #(.WIDE(W), .HIGN(H), .DW(DW), .CNT_DW(CDW), .DRAIN_CYC(DC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .valid_in(valid_in), .data_in1(data_in1), .data_in2(data_in2),
    .valid_match(valid_match), .match_addr(match_addr),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .ovf(ovf),
`ifdef SIFT_SCHED_PERF_EN
    .perf_cyc(perf_cyc),
`endif
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f1(input int a);
    return 8'(a * 3 + 1);
  endfunction
  function automatic logic [7:0] f2(input int a);
    return 8'hA0 ^ 8'(a);
  endfunction

  always @(posedge clk) if (rd_en) begin
    rd_data1 <= f1(int'(rd_addr));
    rd_data2 <= f2(int'(rd_addr));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixel count issued, drain cycles elapsed, result queue
  bit m_ok = 0, m_stream = 0, m_dn = 0, m_vin = 0, m_ovf = 0;
  int m_drain = -1, m_issued = 0, m_cnt = 0;
  logic [7:0] m_d1 = '0, m_d2 = '0;
  logic [31:0] q[$];

  always @(posedge clk) begin : model
    bit idle, pop;
    if (rst) begin
      m_ok = 1; m_stream = 0; m_drain = -1; m_dn = 0; m_issued = 0;
      m_vin = 0; m_ovf = 0; m_cnt = 0; q.delete();
    end else begin
      idle = !m_stream && m_drain < 0 && !m_dn;
      pop = q.size() > 0 && res_ready;
      m_vin = m_stream && !pause;
      if (m_vin) begin m_d1 = f1(m_issued); m_d2 = f2(m_issued); end
      if (idle && start) begin
        q.delete(); m_ovf = 0; m_cnt = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (valid_match) begin
          if (q.size() < FD) q.push_back(match_addr);
          else m_ovf = 1;
        end
        if (!idle && valid_match && m_cnt < 65535) m_cnt++;
      end
      if (m_dn) m_dn = 0;
      else if (m_drain >= 0) begin
        if (abort) m_drain = -1;
        else if (m_drain == DC - 1) begin m_drain = -1; m_dn = 1; end
        else m_drain++;
      end else if (m_stream) begin
        if (!pause) m_issued++;
        if (abort) m_stream = 0;
        else if (m_issued == N) begin m_stream = 0; m_drain = 0; end
      end else if (start) begin
        m_stream = 1; m_issued = 0;
      end
    end
  end

  always @(negedge clk) if (m_ok) begin
    chk("rd_en", rd_en, m_stream && !pause);
    chk("rd_addr", rd_addr, m_issued < N ? m_issued : N - 1);
    chk("valid_in", valid_in, m_vin);
    chk("data_in1", data_in1, m_vin ? m_d1 : 8'h0);
    chk("data_in2", data_in2, m_vin ? m_d2 : 8'h0);
    chk("busy", busy, m_stream || m_drain >= 0);
    chk("done", done, m_dn);
    chk("ovf", ovf, m_ovf);
    chk("match_cnt", match_cnt, m_cnt);
    chk("res_valid", res_valid, q.size() > 0);
    chk("res_data", res_data, q.size() > 0 ? q[0] : 32'h0);
  end

  always @(negedge clk) begin
    if (valid_in === 1'b1) vin_seen++;
    if (done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    tick(); start = 1; tick(); start = 0;
  endtask

  task automatic wait_done(input int bound);
    bit got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    chk("done_reached", got, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [31:0] exp42 [4] = '{32'h00020001, 32'h00030002, 32'h00040003, 32'h00050004};

  initial begin
    int nv, dk, first, v0, d0, n;
    logic [31:0] last;
    repeat (2) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_match_cnt", match_cnt, 0);

    // full frame, with a stray start mid-frame
    start_frame();
    nv = 0; dk = 0; first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_in) begin nv++; if (first == 0) first = k; end
      if (done && dk == 0) dk = k;
      if (k == 5) start = 1;
      if (k == 6) start = 0;
    end
    chk("frame_vin_count", nv, 16);
    chk("frame_first_vin", first, 2);
    chk("frame_done_at", dk, 25);
    chk("frame_busy_after", busy, 0);
    chk("frame_last_addr", rd_addr, 15);

    // pause for 3 cycles at address 5
    start_frame();
    v0 = vin_seen;
    repeat (5) tick();
    pause = 1;
    repeat (3) tick();
    pause = 0;
    @(negedge clk);
    chk("pause_resume_addr", rd_addr, 5);
    chk("pause_resume_rd_en", rd_en, 1);
    chk("pause_gap_vin", valid_in, 0);
    wait_done(60);
    chk("pause_vin_total", vin_seen - v0, 16);

    // overflow: 5 results into a 4-deep FIFO
    start_frame();
    for (int i = 0; i < 5; i++) begin
      valid_match = 1; match_addr = 32'h00020001 + 32'h00010001 * i; tick();
    end
    valid_match = 0;
    @(negedge clk);
    chk("ovf_match_cnt", match_cnt, 5);
    chk("ovf_flag", ovf, 1);
    chk("ovf_head", res_data, 32'h00020001);
    tick(); res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ovf_order", res_data, exp42[i]);
    end
    tick();
    chk("ovf_drained", res_valid, 0);
    res_ready = 0;
    wait_done(60);

    // push and pop together on a full FIFO
    start_frame();
    chk("restart_ovf_clear", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      valid_match = 1; match_addr = 32'h11 + i; tick();
    end
    res_ready = 1; match_addr = 32'h15; tick();
    valid_match = 0; res_ready = 0;
    @(negedge clk);
    chk("fullpp_ovf", ovf, 0);
    chk("fullpp_head", res_data, 32'h12);
    tick(); res_ready = 1;
    n = 0; last = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) begin n++; last = res_data; end
    end
    chk("fullpp_count", n, 4);
    chk("fullpp_tail", last, 32'h15);
    res_ready = 0;
    wait_done(60);

    // abort at address 9
    start_frame();
    repeat (9) tick();
    abort = 1;
    @(negedge clk);
    chk("abort_addr", rd_addr, 9);
    tick(); abort = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    d0 = done_seen;
    repeat (30) tick();
    chk("abort_no_done", done_seen - d0, 0);

    // reset mid-stream with a full, overflowed FIFO
    start_frame();
    for (int i = 0; i < 5; i++) begin
      valid_match = 1; match_addr = 32'hA0 + i; tick();
    end
    valid_match = 0;
    rst = 1; start = 1; tick();
    @(negedge clk);
    chk("mrst_rd_en", rd_en, 0);
    chk("mrst_rd_addr", rd_addr, 0);
    chk("mrst_valid_in", valid_in, 0);
    chk("mrst_data_in1", data_in1, 0);
    chk("mrst_data_in2", data_in2, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_match_cnt", match_cnt, 0);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_res_data", res_data, 0);
    tick(); rst = 0; start = 0;

    start_frame();
    wait_done(60);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sift_frame_sched.md
SIFT_FRAME_SCHED -- requirements
Module: sift_frame_sched

Interface
REQ-001 SHALL have parameter WIDE, default 256, image width in pixels.
REQ-002 SHALL have parameter HIGN, default 256, image height in pixels.
REQ-003 SHALL have parameter DW, default 8, pixel width.
REQ-004 SHALL have parameter CNT_DW, default 16, address/counter width; WIDE*HIGN <= 2**CNT_DW.
REQ-005 SHALL have parameter DRAIN_CYC, default 64, matcher flush cycles after last pixel.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, result FIFO entries (power of 2).
REQ-007 SHALL have one clock; reset is synchronous and active-high; ports are clk and rst.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 start  in  1  begin a frame when idle.
REQ-011 abort  in  1  terminate the current frame.
REQ-012 pause  in  1  suspend pixel issue.
REQ-013 rd_en  out  1  read strobe to both image RAMs.
REQ-014 rd_addr  out  CNT_DW  shared pixel address.
REQ-015 rd_data1 / rd_data2  in  DW each  RAM read data, valid 1 cycle after rd_en.
REQ-016 valid_in  out  1  pixel-pair valid to matcher.
REQ-017 data_in1 / data_in2  out  DW each  pixel pair to matcher.
REQ-018 valid_match  in  1  matcher result strobe.
REQ-019 match_addr  in  2*CNT_DW  result; [2*CNT_DW-1:CNT_DW] image2 address, [CNT_DW-1:0] image1 address.
REQ-020 res_valid / res_ready  out / in  1 each  result FIFO read handshake.
REQ-021 res_data  out  2*CNT_DW  FIFO head entry.
REQ-022 busy, done, ovf  out  1 each  status; match_cnt  out  CNT_DW  results seen this frame.

Function
REQ-023 FSM states: IDLE, STREAM, DRAIN, DONE.
REQ-024 IDLE->STREAM on start: rd_addr=0, match_cnt=0, ovf=0, FIFO flushed; start is ignored outside IDLE.
REQ-025 In STREAM: rd_en = !pause; rd_addr increments by 1 after each cycle with rd_en=1.
REQ-026 The cycle issuing rd_addr=WIDE*HIGN-1 moves to DRAIN; the address never wraps.
REQ-027 valid_in is rd_en delayed by exactly 1 cycle; data_inN = rd_dataN when valid_in=1, else 0.
REQ-028 DRAIN counts DRAIN_CYC cycles, then moves to DONE; DONE lasts 1 cycle with done=1, then IDLE.
REQ-029 busy=1 in STREAM and DRAIN, else 0.
REQ-030 abort in STREAM or DRAIN moves to IDLE next cycle with rd_en=0; no done pulse; FIFO contents kept.
REQ-031 Each cycle with valid_match=1 in STREAM, DRAIN or DONE increments match_cnt, saturating at 2**CNT_DW-1.
REQ-032 valid_match pushes match_addr into the FIFO; when full and not popping, the entry is dropped and ovf sets (sticky until next start).
REQ-033 Pop occurs when res_valid && res_ready; simultaneous push and pop on a full FIFO accepts the push.
REQ-034 res_valid = FIFO non-empty; res_data = head entry, registered; FIFO order is first-in, first-out.

Reset
REQ-035 rst SHALL force IDLE, rd_en=0, rd_addr=0, valid_in=0, data_in1/2=0, busy=0, done=0, ovf=0, match_cnt=0, FIFO empty (res_valid=0, res_data=0), overriding all other inputs, including mid-frame.

Configuration
REQ-036 With SIFT_SCHED_PERF_EN defined: output perf_cyc (32 bits) counts busy cycles with pause=1 in the current frame, clears on start, holds after done.
REQ-037 Without SIFT_SCHED_PERF_EN: perf_cyc is absent, with no counter logic.

Structure
REQ-038 Package sift_sched_pkg SHALL hold the FSM state encoding, default WIDE/HIGN/DW/CNT_DW values and the result entry width 2*CNT_DW.
REQ-039 The result FIFO SHALL be sub-module sift_res_fifo (parameters width, depth; push/pop/full/empty); the rest stays in sift_frame_sched.

Verification (WIDE=4, HIGN=4, DRAIN_CYC=8, FIFO_DEPTH=4)
REQ-040 start pulse, pause=0 -> rd_addr 0..15 over 16 consecutive cycles; valid_in 1 cycle later; done pulse 8 cycles after the final valid_in period plus DONE; busy=0 after.
REQ-041 pause high for 3 cycles at rd_addr=5 -> no rd_en for 3 cycles, address resumes at 5, valid_in gap of 3 cycles, 16 total valid_in.
REQ-042 5 valid_match pulses with values 0x00020001..0x00060005, res_ready=0 -> 4 entries stored, ovf=1, match_cnt=5; then res_ready=1 -> res_data 0x00020001..0x00050004 in order.
REQ-043 FIFO full, valid_match and pop on the same cycle -> entry accepted, ovf stays 0, count stays 4.
REQ-044 abort at rd_addr=9 -> IDLE next cycle, no done pulse; rst asserted mid-STREAM -> all outputs at REQ-035 values next cycle.
REQ-045 start asserted while busy -> ignored, with rd_addr sequence unaffected.
